spi1w_master: RTL and testbench

- Clocked SPI write master that sequences the one-way SPI link into the slave-side register file.
- Arbitrates between two on-chip requesters, each asking to write one 8-bit register.
- Serializes each granted request as a 16-bit frame: address MSB first, then data MSB first.
- Generates CS, SCLK and SDATA for the slave; the register write commits at the CS rising edge.

---
 rtl/spi1w_pkg.sv | 24 ++
 rtl/spi1w_sclk_gen.sv | 43 ++++
 rtl/spi1w_master.sv | 173 +++++++++++++++++
 tb/tb_spi1w_master.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi1w_pkg.sv
// Shared widths, FSM state type and frame packing for the one-way SPI write master.
package spi1w_pkg;

  localparam int FRAME_W  = 16;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int DIV_W    = 8;
  localparam int BITCNT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  // Address goes out first, so it occupies the upper byte of the frame.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/spi1w_sclk_gen.sv
// SCLK divider: toggles the serial clock every CLKDIV cycles while enabled, idles low otherwise.
module spi1w_sclk_gen
  import spi1w_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic last,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLKDIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             sclk_reg;
  logic             terminal;

  assign terminal = en && (div_cnt_reg == '0);
  assign rise     = terminal && !sclk_reg;
  assign fall     = terminal && sclk_reg;
  assign sclk     = sclk_reg;

  // On the final low half-period the rise strobe still fires, but 'last' keeps SCLK low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= RELOAD;
      sclk_reg    <= 1'b0;
    end else if (!en) begin
      div_cnt_reg <= RELOAD;
      sclk_reg    <= 1'b0;
    end else if (terminal) begin
      div_cnt_reg <= RELOAD;
      sclk_reg    <= !sclk_reg && !last;
    end else begin
      div_cnt_reg <= div_cnt_reg - 1'b1;
    end
  end

endmodule

// File: rtl/spi1w_master.sv
// Two-requester SPI write master: grants one request, then shifts {addr,data} out MSB first.
// Define SPI1W_FIXPRIO_EN for fixed priority (requester 0 wins); otherwise round-robin.
module spi1w_master
  import spi1w_pkg::*;
#(
  parameter int CLKDIV = 2,
  parameter int CS_GAP = 2
) (
  input  logic              CLK,
  input  logic              RSTX,
  input  logic              REQ0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] DATA0,
  output logic              ACK0,
  input  logic              REQ1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] DATA1,
  output logic              ACK1,
  output logic              BUSY,
  output logic              CS,
  output logic              SCLK,
  output logic              SDATA
);

  localparam logic [DIV_W-1:0]    HOLD_RELOAD = DIV_W'(CLKDIV - 1);
  localparam logic [DIV_W-1:0]    GAP_RELOAD  = DIV_W'(CS_GAP - 1);
  localparam logic [BITCNT_W-1:0] LAST_BIT    = BITCNT_W'(FRAME_W);

  logic                rst_meta_reg;
  logic                rst_n_sync;
  state_t              state_reg;
  logic [FRAME_W-1:0]  shift_reg;
  logic [BITCNT_W-1:0] bit_cnt_reg;
  logic [DIV_W-1:0]    phase_cnt_reg;
  logic                cs_reg;
  logic                busy_reg;
  logic                ack0_reg;
  logic                ack1_reg;
`ifndef SPI1W_FIXPRIO_EN
  logic                rr_ptr_reg;
`endif
  logic                grant0;
  logic                grant1;
  logic                sclk_en;
  logic                sclk_last;
  logic                sclk_rise;
  logic                sclk_fall;

  // Reset asserts asynchronously but releases two clocks after RSTX rises.
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      rst_meta_reg <= 1'b0;
      rst_n_sync   <= 1'b0;
    end else begin
      rst_meta_reg <= 1'b1;
      rst_n_sync   <= rst_meta_reg;
    end
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_reg == IDLE) begin
`ifdef SPI1W_FIXPRIO_EN
      grant0 = REQ0;
      grant1 = REQ1 && !REQ0;
`else
      if (REQ0 && REQ1) begin
        grant0 = !rr_ptr_reg;
        grant1 = rr_ptr_reg;
      end else begin
        grant0 = REQ0;
        grant1 = REQ1;
      end
`endif
    end
  end

  // SETUP doubles as the leading low half-period, so the divider runs from SETUP onward.
  assign sclk_en   = (state_reg == SETUP) || (state_reg == SHIFT);
  assign sclk_last = (bit_cnt_reg == LAST_BIT);

  spi1w_sclk_gen #(
    .CLKDIV(CLKDIV)
  ) u_sclk_gen (
    .clk  (CLK),
    .rst_n(rst_n_sync),
    .en   (sclk_en),
    .last (sclk_last),
    .sclk (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_ff @(posedge CLK or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      phase_cnt_reg <= '0;
      cs_reg        <= 1'b1;
      busy_reg      <= 1'b0;
      ack0_reg      <= 1'b0;
      ack1_reg      <= 1'b0;
`ifndef SPI1W_FIXPRIO_EN
      rr_ptr_reg    <= 1'b0;
`endif
    end else begin
      ack0_reg <= grant0;
      ack1_reg <= grant1;
`ifndef SPI1W_FIXPRIO_EN
      if (grant0) begin
        rr_ptr_reg <= 1'b1;
      end else if (grant1) begin
        rr_ptr_reg <= 1'b0;
      end
`endif
      case (state_reg)
        IDLE: begin
          if (grant0 || grant1) begin
            shift_reg   <= grant0 ? pack_frame(ADDR0, DATA0) : pack_frame(ADDR1, DATA1);
            bit_cnt_reg <= '0;
            cs_reg      <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= SETUP;
          end
        end
        SETUP: begin
          if (sclk_rise) begin
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          // Zeros shift in behind the frame, so SDATA returns low after the 16th fall.
          if (sclk_fall) begin
            shift_reg   <= {shift_reg[FRAME_W-2:0], 1'b0};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end else if (sclk_rise && sclk_last) begin
            phase_cnt_reg <= HOLD_RELOAD;
            state_reg     <= HOLD;
          end
        end
        HOLD: begin
          if (phase_cnt_reg == '0) begin
            cs_reg        <= 1'b1;
            phase_cnt_reg <= GAP_RELOAD;
            state_reg     <= GAP;
          end else begin
            phase_cnt_reg <= phase_cnt_reg - 1'b1;
          end
        end
        GAP: begin
          if (phase_cnt_reg == '0) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            phase_cnt_reg <= phase_cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ACK0  = ack0_reg;
  assign ACK1  = ack1_reg;
  assign BUSY  = busy_reg;
  assign CS    = cs_reg;
  assign SDATA = shift_reg[FRAME_W-1];

endmodule

// File: tb/tb_spi1w_master.sv
// Directed bench for spi1w_master: main instance CLKDIV=2/CS_GAP=2, fast instance CLKDIV=1/CS_GAP=1,
// each with a slave register-file model that commits a 16-bit frame on CS rising.
module tb_spi1w_master;

  logic       clk = 1'b0;
  logic       rstx = 1'b0;

  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = 8'h00, data0 = 8'h00, addr1 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, busy, cs, sclk, sdata;

  logic       f_req0 = 1'b0, f_req1 = 1'b0;
  logic [7:0] f_addr0 = 8'h00, f_data0 = 8'h00, f_addr1 = 8'h00, f_data1 = 8'h00;
  logic       f_ack0, f_ack1, f_busy, f_cs, f_sclk, f_sdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi1w_master #(.CLKDIV(2), .CS_GAP(2)) u_dut (
    .CLK(clk), .RSTX(rstx),
    .REQ0(req0), .ADDR0(addr0), .DATA0(data0), .ACK0(ack0),
    .REQ1(req1), .ADDR1(addr1), .DATA1(data1), .ACK1(ack1),
    .BUSY(busy), .CS(cs), .SCLK(sclk), .SDATA(sdata)
  );

  spi1w_master #(.CLKDIV(1), .CS_GAP(1)) u_fast (
    .CLK(clk), .RSTX(rstx),
    .REQ0(f_req0), .ADDR0(f_addr0), .DATA0(f_data0), .ACK0(f_ack0),
    .REQ1(f_req1), .ADDR1(f_addr1), .DATA1(f_data1), .ACK1(f_ack1),
    .BUSY(f_busy), .CS(f_cs), .SCLK(f_sclk), .SDATA(f_sdata)
  );

  logic [1:0] s_cs, s_sclk, s_sdata;
  assign s_cs    = {f_cs, cs};
  assign s_sclk  = {f_sclk, sclk};
  assign s_sdata = {f_sdata, sdata};

  // Slave register files: sample SDATA on SCLK rise, commit on CS rise after exactly 16 bits.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slave
    logic [7:0]  regs [256];
    logic [15:0] sh;
    logic [15:0] last_frame;
    logic [4:0]  nbits;
    logic        sclk_q, cs_q;
    always @(posedge clk or negedge rstx) begin
      if (!rstx) begin
        for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
        sh         <= 16'h0000;
        last_frame <= 16'h0000;
        nbits      <= 5'd0;
        sclk_q     <= 1'b0;
        cs_q       <= 1'b1;
      end else begin
        sclk_q <= s_sclk[gi];
        cs_q   <= s_cs[gi];
        if (!s_cs[gi] && s_sclk[gi] && !sclk_q) begin
          sh    <= {sh[14:0], s_sdata[gi]};
          nbits <= nbits + 5'd1;
        end
        if (s_cs[gi] && !cs_q) begin
          if (nbits == 5'd16) begin
            regs[sh[15:8]] <= sh[7:0];
            last_frame     <= sh;
          end
          nbits <= 5'd0;
        end
      end
    end
  end

  task automatic wait_ack(input int inst, input int max_cyc, output int who, output int cyc);
    who = -1;
    cyc = 0;
    while (who < 0 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (inst == 0) begin
        if (ack0) who = 0; else if (ack1) who = 1;
      end else begin
        if (f_ack0) who = 0; else if (f_ack1) who = 1;
      end
    end
  endtask

  task automatic wait_idle(input int inst);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((((inst == 0) ? busy : f_busy) !== 1'b0) && n < 400);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rstx = 1'b0;
    repeat (2) @(negedge clk);
    rstx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rstx = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cs, sclk, sdata, ack0, ack1, busy} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_hold_main: got cs,sclk,sdata,ack0,ack1,busy=%b need 100000",
               {cs, sclk, sdata, ack0, ack1, busy});
    end
    n_cmp++;
    if ({f_cs, f_sclk, f_sdata, f_ack0, f_ack1, f_busy} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_hold_fast: got %b need 100000",
               {f_cs, f_sclk, f_sdata, f_ack0, f_ack1, f_busy});
    end
    rstx = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({cs, sclk, sdata, ack0, ack1, busy} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_release_main: got %b need 100000", {cs, sclk, sdata, ack0, ack1, busy});
    end
    $display("test_reset: reset held and released");
  endtask

  task automatic test_single_write();
    int who, cyc, cs_low, rises, guard;
    logic sclk_p;
    addr0 = 8'h01; data0 = 8'hA5; req0 = 1'b1;
    wait_ack(0, 50, who, cyc);
    req0 = 1'b0;
    n_cmp++;
    if (who !== 0 || cyc !== 1) begin
      n_bad++;
      $display("FAIL single_ack: got who=%0d after %0d cycles need who=0 after 1", who, cyc);
    end
    cs_low = (cs === 1'b0) ? 1 : 0;
    rises  = 0;
    sclk_p = sclk;
    @(negedge clk);
    n_cmp++;
    if (ack0 !== 1'b0) begin
      n_bad++;
      $display("FAIL single_ack_width: got ack0=%b on second cycle need 0", ack0);
    end
    if (cs === 1'b0) cs_low++;
    if (sclk && !sclk_p) rises++;
    sclk_p = sclk;
    guard = 0;
    while (cs === 1'b0 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (cs === 1'b0) cs_low++;
      if (sclk && !sclk_p) rises++;
      sclk_p = sclk;
    end
    n_cmp++;
    if (cs_low !== 68) begin
      n_bad++;
      $display("FAIL single_cs_low: got %0d cycles need 68", cs_low);
    end
    n_cmp++;
    if (rises !== 16) begin
      n_bad++;
      $display("FAIL single_sclk_rises: got %0d need 16", rises);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_busy_gap: got %b need 1", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_busy_idle: got %b need 0", busy);
    end
    n_cmp++;
    if (g_slave[0].last_frame !== 16'h01A5) begin
      n_bad++;
      $display("FAIL single_frame: got %h need 01a5", g_slave[0].last_frame);
    end
    n_cmp++;
    if (g_slave[0].regs[1] !== 8'hA5) begin
      n_bad++;
      $display("FAIL single_reg01: got %h need a5", g_slave[0].regs[1]);
    end
    $display("test_single_write: addr=01 data=a5 cs_low=%0d rises=%0d", cs_low, rises);
  endtask

  task automatic test_arbitration();
    int who, cyc, exp2, exp3;
`ifdef SPI1W_FIXPRIO_EN
    exp2 = 0; exp3 = 1;
`else
    exp2 = 1; exp3 = 0;
`endif
    do_reset();
    addr0 = 8'h00; data0 = 8'h11; addr1 = 8'h01; data1 = 8'h22;
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(0, 200, who, cyc);
    n_cmp++;
    if (who !== 0) begin
      n_bad++;
      $display("FAIL arb_first: got ack%0d need ack0", who);
    end
    $display("test_arbitration: grant 1 to requester %0d", who);
    // Requester 0 keeps REQ0 high with new data: a fresh request contending with requester 1.
    data0 = 8'h33;
    wait_ack(0, 200, who, cyc);
    n_cmp++;
    if (who !== exp2) begin
      n_bad++;
      $display("FAIL arb_second: got ack%0d need ack%0d", who, exp2);
    end
    if (who == 1) req1 = 1'b0; else if (who == 0) req0 = 1'b0;
    $display("test_arbitration: grant 2 to requester %0d", who);
    wait_ack(0, 200, who, cyc);
    n_cmp++;
    if (who !== exp3) begin
      n_bad++;
      $display("FAIL arb_third: got ack%0d need ack%0d", who, exp3);
    end
    req0 = 1'b0; req1 = 1'b0;
    $display("test_arbitration: grant 3 to requester %0d", who);
    wait_idle(0);
    n_cmp++;
    if (g_slave[0].regs[0] !== 8'h33 || g_slave[0].regs[1] !== 8'h22) begin
      n_bad++;
      $display("FAIL arb_regs: got reg00=%h reg01=%h need 33 22",
               g_slave[0].regs[0], g_slave[0].regs[1]);
    end
  endtask

  task automatic test_back_to_back();
    int who, cyc, c, hi, got;
    addr0 = 8'h02; data0 = 8'h5C; req0 = 1'b1;
    wait_ack(0, 200, who, cyc);
    n_cmp++;
    if (who !== 0) begin
      n_bad++;
      $display("FAIL b2b_first_ack: got ack%0d need ack0", who);
    end
    c = 0; hi = 0; got = 0;
    while (got == 0 && c < 300) begin
      @(negedge clk);
      c++;
      if (cs === 1'b1) hi++;
      if (ack0 === 1'b1) got = 1;
    end
    req0 = 1'b0;
    n_cmp++;
    if (got !== 1 || c !== 71) begin
      n_bad++;
      $display("FAIL b2b_ack_spacing: got %0d cycles (seen=%0d) need 71", c, got);
    end
    n_cmp++;
    if (hi !== 3) begin
      n_bad++;
      $display("FAIL b2b_cs_high: got %0d cycles need 3", hi);
    end
    wait_idle(0);
    n_cmp++;
    if (g_slave[0].regs[2] !== 8'h5C) begin
      n_bad++;
      $display("FAIL b2b_reg02: got %h need 5c", g_slave[0].regs[2]);
    end
    $display("test_back_to_back: ack spacing=%0d cs_high=%0d", c, hi);
  endtask

  task automatic test_reset_midframe();
    int who, cyc, rises, guard;
    logic sclk_p;
    addr0 = 8'h00; data0 = 8'hFF; req0 = 1'b1;
    wait_ack(0, 200, who, cyc);
    req0 = 1'b0;
    rises = 0; guard = 0; sclk_p = sclk;
    while (rises < 9 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (sclk && !sclk_p) rises++;
      sclk_p = sclk;
    end
    rstx = 1'b0;
    #1;
    n_cmp++;
    if ({cs, sclk, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL midreset_outputs: got cs,sclk,busy=%b need 100 (rises=%0d)", {cs, sclk, busy}, rises);
    end
    repeat (2) @(negedge clk);
    rstx = 1'b1;
    repeat (80) @(negedge clk);
    n_cmp++;
    if (g_slave[0].regs[0] !== 8'h00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_reg00: got reg00=%h busy=%b need 00 0", g_slave[0].regs[0], busy);
    end
    addr0 = 8'h04; data0 = 8'h9E; req0 = 1'b1;
    wait_ack(0, 200, who, cyc);
    req0 = 1'b0;
    n_cmp++;
    if (who !== 0) begin
      n_bad++;
      $display("FAIL midreset_new_ack: got ack%0d need ack0", who);
    end
    wait_idle(0);
    n_cmp++;
    if (g_slave[0].regs[4] !== 8'h9E) begin
      n_bad++;
      $display("FAIL midreset_reg04: got %h need 9e", g_slave[0].regs[4]);
    end
    $display("test_reset_midframe: reset after %0d rises, recovery write addr=04 data=9e", rises);
  endtask

  task automatic fast_write(input logic [7:0] a, input logic [7:0] d, output int who,
                            output int cs_low, output int rises, output int bad_period,
                            output int bad_edge);
    int cyc, n, last_rise;
    logic sclk_p, sdata_p, cs_p;
    f_addr0 = a; f_data0 = d; f_req0 = 1'b1;
    wait_ack(1, 50, who, cyc);
    f_req0 = 1'b0;
    cs_low = (f_cs === 1'b0) ? 1 : 0;
    rises = 0; bad_period = 0; bad_edge = 0; last_rise = -1; n = 0;
    sclk_p = f_sclk; sdata_p = f_sdata; cs_p = f_cs;
    while (f_cs === 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
      if (f_cs === 1'b0) cs_low++;
      if (f_sclk && !sclk_p) begin
        if (last_rise >= 0 && (n - last_rise) != 2) bad_period++;
        last_rise = n;
        rises++;
      end
      if (!f_cs && !cs_p && (f_sdata !== sdata_p) && !(sclk_p && !f_sclk)) bad_edge++;
      sclk_p = f_sclk; sdata_p = f_sdata; cs_p = f_cs;
    end
    wait_idle(1);
  endtask

  task automatic test_fast();
    int who, cs_low, rises, bad_period, bad_edge;
    fast_write(8'h05, 8'h80, who, cs_low, rises, bad_period, bad_edge);
    n_cmp++;
    if (who !== 0 || cs_low !== 34) begin
      n_bad++;
      $display("FAIL fast_cs_low: got ack%0d cs_low=%0d need ack0 34", who, cs_low);
    end
    n_cmp++;
    if (rises !== 16 || bad_period !== 0) begin
      n_bad++;
      $display("FAIL fast_sclk_period: got rises=%0d bad_periods=%0d need 16 0", rises, bad_period);
    end
    n_cmp++;
    if (bad_edge !== 0) begin
      n_bad++;
      $display("FAIL fast_sdata_edges: got %0d misaligned edges need 0", bad_edge);
    end
    n_cmp++;
    if (g_slave[1].regs[5] !== 8'h80) begin
      n_bad++;
      $display("FAIL fast_reg05_first: got %h need 80", g_slave[1].regs[5]);
    end
    $display("test_fast: addr=05 data=80 cs_low=%0d rises=%0d", cs_low, rises);
    fast_write(8'h05, 8'h01, who, cs_low, rises, bad_period, bad_edge);
    n_cmp++;
    if (bad_edge !== 0 || bad_period !== 0) begin
      n_bad++;
      $display("FAIL fast_second_edges: got bad_edge=%0d bad_period=%0d need 0 0", bad_edge, bad_period);
    end
    n_cmp++;
    if (g_slave[1].regs[5] !== 8'h01) begin
      n_bad++;
      $display("FAIL fast_reg05_second: got %h need 01", g_slave[1].regs[5]);
    end
    $display("test_fast: addr=05 data=01 cs_low=%0d rises=%0d", cs_low, rises);
  endtask

  task automatic test_midframe_req1();
    int who, cyc, early, n;
    addr0 = 8'h06; data0 = 8'h12; req0 = 1'b1;
    wait_ack(0, 200, who, cyc);
    req0 = 1'b0;
    repeat (20) @(negedge clk);
    addr1 = 8'h07; data1 = 8'h34; req1 = 1'b1;
    early = 0; n = 0;
    while (busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      if (ack1 === 1'b1) early++;
    end
    n_cmp++;
    if (early !== 0 || busy !== 1'b0 || ack1 !== 1'b0) begin
      n_bad++;
      $display("FAIL midreq_early_ack: got early=%0d busy=%b ack1=%b need 0 0 0", early, busy, ack1);
    end
    @(negedge clk);
    n_cmp++;
    if (ack1 !== 1'b1) begin
      n_bad++;
      $display("FAIL midreq_ack1_timing: got ack1=%b one cycle after idle need 1", ack1);
    end
    req1 = 1'b0;
    wait_idle(0);
    n_cmp++;
    if (g_slave[0].regs[7] !== 8'h34) begin
      n_bad++;
      $display("FAIL midreq_reg07: got %h need 34", g_slave[0].regs[7]);
    end
    $display("test_midframe_req1: req1 granted after idle, addr=07 data=34");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_arbitration();
    test_back_to_back();
    test_reset_midframe();
    test_fast();
    test_midframe_req1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
